// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned XLEN = 32;

  // Fetch FSM encodings
  localparam logic [1:0] ST_IDLE = 2'd0;  // nothing outstanding
  localparam logic [1:0] ST_WAIT = 2'd1;  // outstanding, response kept
  localparam logic [1:0] ST_DROP = 2'd2;  // outstanding, response discarded

  // One buffered instruction handed to the core
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            err;
  } fetch_entry_t;

  // Clear the byte offset of an address
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small registered FIFO of fetched entries; head drives the core directly.
module fetch_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A push on a full FIFO is only taken when the head leaves the same cycle
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; flush empties without touching storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mem    <= '{default: '0};
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues single outstanding word
// reads, buffers responses and restarts on core redirects.
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    state, state_nx;
  logic [31:0]   fpc, fpc_nx;
  logic [31:0]   req_pc;
  logic [31:0]   pend_addr;
  logic          pend, pend_nx;
  logic          pend_drop, pend_drop_nx;
  logic          outstanding;
  logic          issue;
  logic          acc;
  logic          drop_acc;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  fetch_entry_t  push_data;
  fetch_entry_t  head;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign inst_valid = !fifo_empty;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;
  assign inst_err   = head.err;
  assign push_data  = '{inst: imem_rsp_data, pc: req_pc, err: imem_rsp_err};

  // Issue decision, request channel and FSM next state
  always_comb begin
    state_nx       = state;
    fpc_nx         = fpc;
    outstanding    = (state != ST_IDLE);
    pop            = inst_valid && inst_ready && !redirect_valid;
    push           = imem_rsp_valid && (state == ST_WAIT) && !redirect_valid &&
                     (!fifo_full || pop);
    count_nx       = count + CW'(push) - CW'(pop);
    // New request only if nothing stays in flight and a slot is reserved for it
    issue          = !redirect_valid && !(outstanding && !imem_rsp_valid) &&
                     (count_nx < CW'(FIFO_DEPTH));
    imem_req_valid = rst_n && (pend || issue);
    imem_req_addr  = pend ? pend_addr : fpc;
    acc            = imem_req_valid && imem_req_ready;
    drop_acc       = acc && ((pend && pend_drop) || redirect_valid);
    pend_nx        = imem_req_valid && !imem_req_ready;
    pend_drop_nx   = pend_nx && ((pend && pend_drop) || redirect_valid);

    if (acc) begin
      state_nx = drop_acc ? ST_DROP : ST_WAIT;
    end else if (imem_rsp_valid && outstanding) begin
      state_nx = ST_IDLE;
    end else if (redirect_valid && (state == ST_WAIT)) begin
      state_nx = ST_DROP;
    end

    if (redirect_valid) begin
      fpc_nx = align_word(redirect_pc);
    end else if (acc && !drop_acc) begin
      fpc_nx = fpc + 32'd4;
    end
  end

  // FSM state, fetch PC and held-request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      fpc       <= RESET_PC;
      req_pc    <= '0;
      pend      <= 1'b0;
      pend_addr <= '0;
      pend_drop <= 1'b0;
    end else begin
      state     <= state_nx;
      fpc       <= fpc_nx;
      pend      <= pend_nx;
      pend_drop <= pend_drop_nx;
      if (acc && !drop_acc) begin
        req_pc <= imem_req_addr;
      end
      if (pend_nx) begin
        pend_addr <= imem_req_addr;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a 1-cycle instruction memory model.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  bit          rsp_en;
  logic [31:0] err_addr;

  logic [31:0] pop_pc[$];
  logic [31:0] pop_inst[$];
  logic        pop_err[$];
  int          pop_cyc[$];

  always #5 clk = ~clk;

  inst_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_err       (inst_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic clear_log();
    pop_pc.delete();
    pop_inst.delete();
    pop_err.delete();
    pop_cyc.delete();
  endtask

  // One clock: sample at negedge, then memory answers accepted request next cycle
  task automatic step();
    logic        acc;
    logic [31:0] addr;
    @(negedge clk);
    acc  = rst_n && imem_req_valid && imem_req_ready;
    addr = imem_req_addr;
    if (inst_valid && inst_ready) begin
      pop_pc.push_back(inst_pc);
      pop_inst.push_back(inst);
      pop_err.push_back(inst_err);
      pop_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_rsp_valid = acc && rsp_en;
    imem_rsp_data  = acc ? mem_word(addr) : 32'h0;
    imem_rsp_err   = acc && (addr == err_addr);
  endtask

  task automatic collect(input int n, input int budget, output bit ok);
    int k = 0;
    while (pop_pc.size() < n && k < budget) begin
      step();
      k++;
    end
    ok = (pop_pc.size() >= n);
  endtask

  task automatic do_reset(input logic rdy);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b1;
    imem_req_ready = rdy;
    repeat (2) step();
    rst_n = 1'b1;
    cyc   = 0;
    clear_log();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; imem_rsp_err = 1'b0;
    rsp_en = 1'b1; err_addr = 32'h1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
    n_cmp++; if (inst !== 32'h0) begin n_bad++; $display("FAIL reset_inst: got %h expected 0", inst); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_bad++; $display("FAIL reset_inst_pc: got %h expected 0", inst_pc); end
    n_cmp++; if (inst_err !== 1'b0) begin n_bad++; $display("FAIL reset_inst_err: got %b expected 0", inst_err); end
    rst_n = 1'b1;
    cyc = 0;
    clear_log();
    #1;
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL first_req_valid: got %b expected 1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 32'h8000_0000) begin n_bad++; $display("FAIL first_req_addr: got %h expected 80000000", imem_req_addr); end
  endtask

  task automatic test_stream();
    bit ok;
    collect(6, 30, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL stream_timeout: got %0d pops expected 6", pop_pc.size()); end
    if (ok) begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (pop_pc[i] !== 32'h8000_0000 + 32'(4 * i) || pop_inst[i] !== mem_word(32'h8000_0000 + 32'(4 * i))) begin
          n_bad++;
          $display("FAIL stream_entry%0d: got pc=%h inst=%h expected pc=%h", i, pop_pc[i], pop_inst[i], 32'h8000_0000 + 32'(4 * i));
        end
      end
      n_cmp++; if (pop_cyc[0] != 2) begin n_bad++; $display("FAIL stream_latency: got cycle %0d expected 2", pop_cyc[0]); end
      n_cmp++; if (pop_cyc[5] - pop_cyc[0] != 5) begin n_bad++; $display("FAIL stream_rate: got %0d cycles expected 5", pop_cyc[5] - pop_cyc[0]); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n0;
    inst_ready = 1'b0;
    repeat (10) step();
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL stall_req_valid: got %b expected 0", imem_req_valid); end
    n_cmp++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL stall_inst_valid: got %b expected 1", inst_valid); end
    inst_ready = 1'b1;
    n0 = pop_pc.size();
    collect(n0 + 6, 30, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL resume_timeout: got %0d pops expected %0d", pop_pc.size(), n0 + 6); end
    for (int i = 0; i < pop_pc.size(); i++) begin
      n_cmp++;
      if (pop_pc[i] !== 32'h8000_0000 + 32'(4 * i)) begin
        n_bad++;
        $display("FAIL resume_seq%0d: got pc=%h expected %h", i, pop_pc[i], 32'h8000_0000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_rsp();
    bit ok;
    int k = 0;
    while (imem_rsp_valid !== 1'b1 && k < 10) begin step(); k++; end
    n_cmp++; if (imem_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL redir_rsp_setup: got rsp_valid %b expected 1", imem_rsp_valid); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0203;
    step();
    redirect_valid = 1'b0;
    clear_log();
    #1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL redir_flush: got inst_valid %b expected 0", inst_valid); end
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin n_bad++; $display("FAIL redir_req: got valid=%b addr=%h expected 1/80000200", imem_req_valid, imem_req_addr); end
    collect(3, 20, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL redir_timeout: got %0d pops expected 3", pop_pc.size()); end
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (pop_pc[i] !== 32'h8000_0200 + 32'(4 * i) || pop_inst[i] !== mem_word(32'h8000_0200 + 32'(4 * i))) begin
          n_bad++;
          $display("FAIL redir_entry%0d: got pc=%h inst=%h expected pc=%h", i, pop_pc[i], pop_inst[i], 32'h8000_0200 + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFFC; exp_pc[1] = 32'h0000_0000; exp_pc[2] = 32'h0000_0004;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    clear_log();
    collect(3, 20, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_timeout: got %0d pops expected 3", pop_pc.size()); end
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (pop_pc[i] !== exp_pc[i]) begin n_bad++; $display("FAIL wrap_entry%0d: got pc=%h expected %h", i, pop_pc[i], exp_pc[i]); end
      end
    end
  endtask

  task automatic test_err();
    bit ok;
    err_addr = 32'h8000_0008;
    do_reset(1'b1);
    collect(5, 30, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL err_timeout: got %0d pops expected 5", pop_pc.size()); end
    if (ok) begin
      n_cmp++; if (pop_pc[2] !== 32'h8000_0008 || pop_err[2] !== 1'b1) begin n_bad++; $display("FAIL err_flag: got pc=%h err=%b expected 80000008/1", pop_pc[2], pop_err[2]); end
      n_cmp++; if (pop_pc[3] !== 32'h8000_000C || pop_err[3] !== 1'b0) begin n_bad++; $display("FAIL err_next: got pc=%h err=%b expected 8000000c/0", pop_pc[3], pop_err[3]); end
      n_cmp++; if (pop_err[1] !== 1'b0) begin n_bad++; $display("FAIL err_prev: got err=%b expected 0", pop_err[1]); end
    end
    err_addr = 32'h1;
  endtask

  task automatic test_redirect_pending();
    bit ok;
    do_reset(1'b0);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
        n_bad++;
        $display("FAIL pend_hold%0d: got valid=%b addr=%h expected 1/80000000", i, imem_req_valid, imem_req_addr);
      end
      step();
      redirect_valid = 1'b0;
    end
    imem_req_ready = 1'b1;
    collect(2, 20, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL pend_timeout: got %0d pops expected 2", pop_pc.size()); end
    if (ok) begin
      n_cmp++; if (pop_pc[0] !== 32'h8000_0100) begin n_bad++; $display("FAIL pend_first: got pc=%h expected 80000100", pop_pc[0]); end
      n_cmp++; if (pop_pc[1] !== 32'h8000_0104) begin n_bad++; $display("FAIL pend_second: got pc=%h expected 80000104", pop_pc[1]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    rsp_en = 1'b0;
    step();
    rsp_en = 1'b1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL mid_req_valid: got %b expected 0", imem_req_valid); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL mid_inst_valid: got %b expected 0", inst_valid); end
    n_cmp++; if (inst !== 32'h0 || inst_pc !== 32'h0 || inst_err !== 1'b0) begin n_bad++; $display("FAIL mid_inst_fields: got inst=%h pc=%h err=%b expected 0", inst, inst_pc, inst_err); end
    repeat (2) step();
    rst_n = 1'b1;
    cyc = 0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    imem_rsp_err   = 1'b1;
    step();
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL late_rsp: got inst_valid %b expected 0", inst_valid); end
    imem_req_ready = 1'b1;
    clear_log();
    collect(2, 20, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL mid_timeout: got %0d pops expected 2", pop_pc.size()); end
    if (ok) begin
      n_cmp++;
      if (pop_pc[0] !== 32'h8000_0000 || pop_inst[0] !== mem_word(32'h8000_0000) || pop_err[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_restart: got pc=%h inst=%h err=%b expected 80000000/%h/0", pop_pc[0], pop_inst[0], pop_err[0], mem_word(32'h8000_0000));
      end
      n_cmp++; if (pop_pc[1] !== 32'h8000_0004) begin n_bad++; $display("FAIL mid_second: got pc=%h expected 80000004", pop_pc[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_rsp();
    test_wrap();
    test_err();
    test_redirect_pending();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
